// File: rtl/vreg_pkg.sv
// ============================================================================
// Module      : vreg_pkg
// Description : Shared constants, length-width helper and element/vector
//               types for the vector register file.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package vreg_pkg;

    localparam int VREG_NREGS = 16;
    localparam int VREG_LANES = 16;
    localparam int VREG_EW    = 16;

    // A length must encode 0..lanes inclusive, hence lanes+1 codes.
    function automatic int lenWidth(input int lanes);
        return $clog2(lanes + 1);
    endfunction

    typedef logic [VREG_EW-1:0]                    vreg_elem_t;
    typedef vreg_elem_t [VREG_LANES-1:0]           vreg_vec_t;
    typedef logic [lenWidth(VREG_LANES)-1:0]       vreg_len_t;

endpackage

`default_nettype wire

// File: rtl/vreg_len_next.sv
// ============================================================================
// Module      : vreg_len_next
// Description : Next-length computation for one register: port A length
//               (saturated), port B extension and their collision merge.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module vreg_len_next
    import vreg_pkg::*;
#(
    parameter int LANES = VREG_LANES,
    parameter int IW    = $clog2(LANES),
    parameter int LW    = lenWidth(LANES)
) (
    input  logic [LW-1:0] curLen,
    input  logic          aEn,
    input  logic [LW-1:0] aLen,
    input  logic          bEn,
    input  logic [IW-1:0] bIdx,
    output logic [LW-1:0] nextLen
);

    localparam logic [LW-1:0] c_full = LW'(LANES);

    logic [LW-1:0] w_aSat;
    logic [LW-1:0] w_lenA;
    logic [LW-1:0] w_bExt;

    assign w_aSat = (aLen > c_full) ? c_full : aLen;
    assign w_lenA = aEn ? w_aSat : curLen;
    assign w_bExt = LW'(bIdx) + LW'(1);

    // Port B only ever grows the length established by port A (or the current one).
    assign nextLen = (bEn && (LW'(bIdx) >= w_lenA)) ? w_bExt : w_lenA;

endmodule

`default_nettype wire

// File: rtl/vreg_file_param.sv
// ============================================================================
// Module      : vreg_file_param
// Description : Parametrised vector register file with two vector read ports,
//               one element read port, masked vector write, element write and
//               a busy scoreboard. Optional write-through: VREG_BYPASS_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module vreg_file_param
    import vreg_pkg::*;
#(
    parameter int NREGS = VREG_NREGS,
    parameter int LANES = VREG_LANES,
    parameter int EW    = VREG_EW,
    parameter int AW    = $clog2(NREGS),
    parameter int IW    = $clog2(LANES),
    parameter int LW    = lenWidth(LANES)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [AW-1:0]       rAddr0,
    output logic [LANES*EW-1:0] rData0,
    output logic [LW-1:0]       rLen0,
    input  logic [AW-1:0]       rAddr1,
    output logic [LANES*EW-1:0] rData1,
    output logic [LW-1:0]       rLen1,
    input  logic [AW-1:0]       rAddr2,
    input  logic [IW-1:0]       rIdx2,
    output logic [EW-1:0]       rElem2,
    output logic                rElemValid2,
    input  logic                wEnA,
    input  logic [AW-1:0]       wAddrA,
    input  logic [LANES-1:0]    wMaskA,
    input  logic                wLenEnA,
    input  logic [LW-1:0]       wLenA,
    input  logic [LANES*EW-1:0] wDataA,
    input  logic                wEnB,
    input  logic [AW-1:0]       wAddrB,
    input  logic [IW-1:0]       wIdxB,
    input  logic [EW-1:0]       wDataB,
    input  logic                rsvEn,
    input  logic [AW-1:0]       rsvAddr,
    output logic [NREGS-1:0]    busy
);

    logic [LANES*EW-1:0] r_data     [NREGS];
    logic [LW-1:0]       r_len      [NREGS];
    logic [NREGS-1:0]    r_busy;

    logic [LANES*EW-1:0] w_nextData [NREGS];
    logic [LW-1:0]       w_nextLen  [NREGS];
    logic [LANES*EW-1:0] w_viewData [NREGS];
    logic [LW-1:0]       w_viewLen  [NREGS];
    logic [NREGS-1:0]    w_busyClr;
    logic [NREGS-1:0]    w_busySet;
    logic [LANES*EW-1:0] w_elemVec;

    for (genvar g = 0; g < NREGS; g++) begin : g_reg
        logic                w_hitA;
        logic                w_hitB;
        logic [LANES*EW-1:0] w_laneNext;

        assign w_hitA = wEnA && (wAddrA == AW'(g));
        assign w_hitB = wEnB && (wAddrB == AW'(g));

        // Port B is applied last so it wins its lane on a same-register collision.
        always_comb begin
            w_laneNext = r_data[g];
            for (int i = 0; i < LANES; i++) begin
                if (w_hitA && wMaskA[i]) begin
                    w_laneNext[i*EW +: EW] = wDataA[i*EW +: EW];
                end
                if (w_hitB && (wIdxB == IW'(i))) begin
                    w_laneNext[i*EW +: EW] = wDataB;
                end
            end
        end

        assign w_nextData[g] = w_laneNext;

        vreg_len_next #(
            .LANES (LANES),
            .IW    (IW),
            .LW    (LW)
        ) u_lenNext (
            .curLen  (r_len[g]),
            .aEn     (w_hitA && wLenEnA),
            .aLen    (wLenA),
            .bEn     (w_hitB),
            .bIdx    (wIdxB),
            .nextLen (w_nextLen[g])
        );

`ifdef VREG_BYPASS_EN
        // Reads see the state about to be committed, except while in reset.
        assign w_viewData[g] = rst ? r_data[g] : w_laneNext;
        assign w_viewLen[g]  = rst ? r_len[g]  : w_nextLen[g];
`else
        assign w_viewData[g] = r_data[g];
        assign w_viewLen[g]  = r_len[g];
`endif
    end

    assign w_busyClr = (wEnA && wLenEnA) ? (NREGS'(1) << wAddrA) : '0;
    assign w_busySet = rsvEn ? (NREGS'(1) << rsvAddr) : '0;

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int r = 0; r < NREGS; r++) begin
                r_data[r] <= '0;
                r_len[r]  <= '0;
            end
            r_busy <= '0;
        end else begin
            for (int r = 0; r < NREGS; r++) begin
                r_data[r] <= w_nextData[r];
                r_len[r]  <= w_nextLen[r];
            end
            // A new reservation overrides a completing write on the same register.
            r_busy <= (r_busy & ~w_busyClr) | w_busySet;
        end
    end

    assign rData0      = w_viewData[rAddr0];
    assign rLen0       = w_viewLen[rAddr0];
    assign rData1      = w_viewData[rAddr1];
    assign rLen1       = w_viewLen[rAddr1];
    assign w_elemVec   = w_viewData[rAddr2];
    assign rElem2      = w_elemVec[rIdx2*EW +: EW];
    assign rElemValid2 = LW'(rIdx2) < w_viewLen[rAddr2];
    assign busy        = r_busy;

endmodule

`default_nettype wire

// File: doc/vreg_file_param.md
Name: vreg_file_param

Overview:
Parametrised vector register file, next generation of the core's vector register storage. It holds NREGS registers, each LANES elements of EW bits plus a length field wide enough to encode a full register (0..LANES).
- Ports: two full-vector read ports, one element read port, one masked full-vector write port and one element write port.
- A per-register busy scoreboard lets the issue stage track in-flight vector writes.

Parameters:
NREGS, 16, number of vector registers (power of 2, >=2)
LANES, 16, elements per register
EW, 16, element width in bits
AW, $clog2(NREGS), register address width (derived)
IW, $clog2(LANES), element index width (derived)
LW, $clog2(LANES+1), length field width (derived; 5 at defaults)

Ports:
clk  in  1  clock, all state updates on rising edge
rst  in  1  synchronous active-high reset
rAddr0  in  AW  read port 0 register address
rData0  out  LANES*EW  read port 0 vector, lane i at bits [i*EW +: EW]
rLen0  out  LW  read port 0 length
rAddr1  in  AW  read port 1 register address
rData1  out  LANES*EW  read port 1 vector
rLen1  out  LW  read port 1 length
rAddr2  in  AW  element read register address
rIdx2  in  IW  element read index
rElem2  out  EW  element read data
rElemValid2  out  1  high when rIdx2 < length of rAddr2
wEnA  in  1  vector write enable
wAddrA  in  AW  vector write register
wMaskA  in  LANES  per-lane write mask
wLenEnA  in  1  when high, length of wAddrA <= wLenA
wLenA  in  LW  new length; values > LANES saturate to LANES
wDataA  in  LANES*EW  vector write data
wEnB  in  1  element write enable
wAddrB  in  AW  element write register
wIdxB  in  IW  element write index
wDataB  in  EW  element write data
rsvEn  in  1  set busy bit of rsvAddr
rsvAddr  in  AW  register to reserve
busy  out  NREGS  scoreboard, bit r high while register r has a pending write

Behaviour:
- Reads are combinational, 0-cycle latency. Writes take effect at the next rising edge (1-cycle latency).
- Reset (rst high at an edge) takes priority over every other input:
  - all data and all lengths cleared to 0, busy cleared to 0
  - after reset, rData0/1 = 0, rLen0/1 = 0, rElem2 = 0, rElemValid2 = 0
  - a write asserted in a reset cycle is discarded
- Port A write: lane i of wAddrA is written only if wMaskA[i]=1. The length changes only if wLenEnA=1. An all-zero mask with wLenEnA=1 updates the length only.
- Port B write: wDataB goes to lane wIdxB of wAddrB. If wIdxB >= current length, the length becomes wIdxB+1; otherwise the length is unchanged. Length never shrinks via port B.
- A and B same register, same cycle:
  - lane data: port B wins on lane wIdxB; all other masked lanes come from A.
  - resulting length = max(A-computed length, wIdxB+1) when wIdxB >= the A-computed length; otherwise the A-computed length.
- Busy scoreboard:
  - A port-A write with wLenEnA=1 clears busy[wAddrA]; a port-B write never clears busy.
  - rsvEn sets busy[rsvAddr].
  - Set and clear on the same register in the same cycle: set wins (a new reservation follows the completing write).
  - Reserving an already-busy register leaves it busy, with no error.
- Element read: rElem2 always returns the stored lane, regardless of length. rElemValid2 = (rIdx2 < length).
- No internal FSM beyond the storage and scoreboard registers. Read ports never stall. Register and lane addresses are fully decoded, so nothing falls out of range.

Optional Feature:
Macro VREG_BYPASS_EN.
- Defined: read ports 0/1/2 forward same-cycle writes (write-through). A read whose address matches an active wAddrA/wAddrB sees the data and length that will be committed at the next edge, merged per the collision rules above. rElemValid2 uses the forwarded length. Forwarding is suppressed while rst=1.
- Undefined: reads return only committed state; a same-cycle write is visible from the following cycle.

Decomposition:
- Shared package vreg_pkg holds:
  - default constants: VREG_NREGS, VREG_LANES, VREG_EW
  - length-width helper function
  - typedef for element (logic [EW-1:0]) and vector (packed array of LANES elements)
  - typedef vreg_len_t
- One natural sub-module, vreg_len_next: combinational next-length computation (A length, B extension, saturation, collision max). It is shared by the commit path and the bypass path.

Test Plan:
- Reset then read all registers -> rData0/1 = 0, rLen0/1 = 0, busy = 0, rElemValid2 = 0.
- Port A write reg 3, mask 16'h00FF, lanes = lane index, wLenEnA=1, wLenA=8 -> next cycle lanes 0..7 = 0..7, lanes 8..15 = 0, rLen0 = 8. Port A with wLenA=31 -> length 16.
- Port B write reg 5, idx 15, data 16'hBEEF on an empty register -> rLen = 16, rElem2 at idx 15 = 16'hBEEF. Port B write idx 2 afterwards -> length stays 16.
- Same cycle: A writes reg 7 all lanes 16'h1111 with length 4, B writes reg 7 idx 9 = 16'h2222 -> lane 9 = 16'h2222, other lanes 16'h1111, length 10.
- Reserve reg 2 -> busy[2]=1. Port A write reg 2 with wLenEnA=1 plus rsvEn on reg 2 in the same cycle -> busy[2] stays 1. Port A write alone -> busy[2]=0.
- With VREG_BYPASS_EN: write reg 1 while rAddr0=1 -> rData0 shows new data in the same cycle. Without the macro -> old data until the next cycle. A write during rst=1 is never committed.
